// File: rtl/iir_filter.sv
// First-order IIR filter on signed Q(N_BITS-FRAC_BITS).FRAC_BITS samples:
//   y[n] = b0*x[n] + b1*x[n-1] + a*y[n-1] + offset
// One sample per clock. The whole datapath is single-cycle and the output is
// registered. Each product is truncated toward -inf. The sum saturates to the
// signed N_BITS range, so an unstable feedback holds the output at a rail
// instead of letting it wrap.
module iir_filter #(
  parameter int N_BITS    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] x_i,
  input  logic [N_BITS-1:0] b0_i,
  input  logic [N_BITS-1:0] b1_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] offset_i,
  output logic [N_BITS-1:0] y_o
);

  localparam int PW = 2 * N_BITS;  // full product width
  localparam int SW = PW + 2;      // sum width: three products plus offset cannot overflow

  // Saturation limits, sign-extended to the sum width.
  localparam logic signed [SW-1:0] MAX_V = {{(SW-N_BITS+1){1'b0}}, {(N_BITS-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-N_BITS+1){1'b1}}, {(N_BITS-1){1'b0}}};

  logic [N_BITS-1:0]        x_q;   // previous input sample x[n-1]
  logic [N_BITS-1:0]        x_d;
  logic [N_BITS-1:0]        y_d;

  logic signed [PW-1:0]     p0, p1, p2;
  logic signed [PW-1:0]     s0, s1, s2;
  logic signed [SW-1:0]     sum;

  // Full-width signed products, then arithmetic shift (floor, no rounding).
  always_comb begin
    p0  = $signed(b0_i) * $signed(x_i);
    p1  = $signed(b1_i) * $signed(x_q);
    p2  = $signed(a_i)  * $signed(y_o);
    s0  = p0 >>> FRAC_BITS;
    s1  = p1 >>> FRAC_BITS;
    s2  = p2 >>> FRAC_BITS;
    sum = $signed({{2{s0[PW-1]}}, s0})
        + $signed({{2{s1[PW-1]}}, s1})
        + $signed({{2{s2[PW-1]}}, s2})
        + $signed({{(SW-N_BITS){offset_i[N_BITS-1]}}, offset_i});
  end

  // Clamp the wide sum into the output range and select the next delay-line value.
  always_comb begin
    y_d = sum[N_BITS-1:0];
    if (sum > MAX_V) begin
      y_d = {1'b0, {(N_BITS-1){1'b1}}};
    end else if (sum < MIN_V) begin
      y_d = {1'b1, {(N_BITS-1){1'b0}}};
    end
    x_d = x_i;
  end

  // State update. Reset clears both taps at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_o <= '0;
    end else begin
      x_q <= x_d;
      y_o <= y_d;
    end
  end

endmodule

// File: tb/tb_iir_filter.sv
// Bench for iir_filter. A driver applies directed samples and pushes the
// hand-computed output into exp_q. A monitor pops the queue on every falling
// edge and compares the popped value against y_o.
module tb_iir_filter;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic [N-1:0] x_i, b0_i, b1_i, a_i, offset_i;
  logic [N-1:0] y_o;

  logic [N-1:0] exp_q[$];
  int           checks;
  int           errors;
  int           vec_idx;

  iir_filter #(.N_BITS(N), .FRAC_BITS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .x_i      (x_i),
    .b0_i     (b0_i),
    .b1_i     (b1_i),
    .a_i      (a_i),
    .offset_i (offset_i),
    .y_o      (y_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: y_o=%h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the registered output is stable at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [N-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", vec_idx), y_o, e);
      vec_idx++;
    end
  end

  // Driver tasks. Each call starts away from a clock edge.
  task automatic set_cfg(input logic [N-1:0] b0, input logic [N-1:0] b1,
                         input logic [N-1:0] a, input logic [N-1:0] off);
    b0_i = b0; b1_i = b1; a_i = a; offset_i = off;
  endtask

  task automatic step(input logic [N-1:0] x, input logic [N-1:0] exp);
    x_i = x;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs never compared, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    vec_idx = 0;
    reset   = 1'b1;
    x_i     = '0;
    set_cfg(32'h0, 32'h0, 32'h0, 32'h0);
    #3;
    check("reset_initial", y_o, 32'h0);
    do_reset();

    // Reset clears nonzero state immediately and holds until the first edge.
    set_cfg(32'h0, 32'h0, 32'h0, 32'h0003_0000);
    step(32'h0, 32'h0003_0000);
    drain();
    #1;
    reset = 1'b1;
    #1;
    check("reset_async", y_o, 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold", y_o, 32'h0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("reset_release", y_o, 32'h0);

    // Two-tap average of a step input.
    do_reset();
    set_cfg(32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0);
    step(32'h0001_0000, 32'h0000_8000);
    step(32'h0001_0000, 32'h0001_0000);
    step(32'h0001_0000, 32'h0001_0000);
    drain();

    // Feedback decay of a single impulse.
    do_reset();
    set_cfg(32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0);
    step(32'h0001_0000, 32'h0001_0000);
    step(32'h0,         32'h0000_8000);
    step(32'h0,         32'h0000_4000);
    step(32'h0,         32'h0000_2000);
    drain();

    // Offset alone, then a negative sample through b0.
    do_reset();
    set_cfg(32'h0, 32'h0, 32'h0, 32'h0002_0000);
    step(32'h0001_2345, 32'h0002_0000);
    set_cfg(32'h0001_0000, 32'h0, 32'h0, 32'h0);
    step(32'hFFFF_0000, 32'hFFFF_0000);
    drain();

    // The b1 tap uses the previous sample: 0.5*x[n] - 0.25*x[n-1].
    do_reset();
    set_cfg(32'h0000_8000, 32'hFFFF_C000, 32'h0, 32'h0);
    step(32'h0004_0000, 32'h0002_0000);
    step(32'h0000_0000, 32'hFFFF_0000);
    drain();

    // Truncation toward -inf.
    do_reset();
    set_cfg(32'h0000_8000, 32'h0, 32'h0, 32'h0);
    step(32'h0000_0001, 32'h0000_0000);
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Saturation at both rails, then unstable feedback pinned at the rail.
    do_reset();
    set_cfg(32'h7FFF_0000, 32'h0, 32'h0, 32'h0);
    step(32'h0002_0000, 32'h7FFF_FFFF);
    step(32'hFFFE_0000, 32'h8000_0000);
    set_cfg(32'h7FFF_0000, 32'h0, 32'h0001_0000, 32'h0);
    step(32'hFFFE_0000, 32'h8000_0000);
    step(32'hFFFE_0000, 32'h8000_0000);
    step(32'hFFFE_0000, 32'h8000_0000);
    drain();

    // Positive rail holds under a = 1.0 with a positive offset.
    do_reset();
    set_cfg(32'h0, 32'h0, 32'h0001_0000, 32'h7000_0000);
    step(32'h0, 32'h7000_0000);
    step(32'h0, 32'h7FFF_FFFF);
    step(32'h0, 32'h7FFF_FFFF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iir_filter.md
Name: iir_filter

Overview:
- First-order (single-pole, two-zero-tap) IIR filter on signed fixed-point samples, one new sample per clock.
- Computes y[n] = b0·x[n] + b1·x[n-1] + a·y[n-1] + offset.
- Sits in the sample-processing datapath after the input sample source; feeds downstream sample consumers or logging.
- All coefficients and the offset are static configuration inputs driven by the surrounding control logic.

Parameters:
- N_BITS, 32, width of samples, coefficients, offset and output.
- FRAC_BITS, 16, fractional bits of the signed Q(N_BITS-FRAC_BITS).FRAC_BITS format (default Q16.16; 1.0 = 0x00010000).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- x_i  input  N_BITS  input sample x[n], signed Q16.16, sampled every rising edge.
- b0_i  input  N_BITS  feed-forward coefficient for x[n], signed Q16.16.
- b1_i  input  N_BITS  feed-forward coefficient for x[n-1], signed Q16.16.
- a_i  input  N_BITS  feedback coefficient for y[n-1], signed Q16.16, added (positive sign convention).
- offset_i  input  N_BITS  constant added to every output, signed Q16.16.
- y_o  output  N_BITS  filtered sample y[n], signed Q16.16, registered.

Behaviour:
- One clock, asynchronous active-high reset.
- State registers:
  - x_d: previous input sample.
  - y_o: output register, doubling as y[n-1].
- Reset asserted, at any time including mid-stream:
  - x_d and y_o go to 0 immediately, with no clock required.
  - Both hold 0 while reset is high.
- Each rising edge with reset low:
  - Products: p0 = b0_i·x_i, p1 = b1_i·x_d, p2 = a_i·y_o. Each is a full 2·N_BITS signed product.
  - Product scaling: arithmetic shift right by FRAC_BITS, i.e. floor/truncation toward −∞. No rounding.
  - Sum: scaled p0 + scaled p1 + scaled p2 + sign-extended offset_i, formed at ≥ N_BITS+FRAC_BITS+2 bits so there is no intermediate overflow.
  - Saturation: the sum is clamped to [0x80000000, 0x7FFFFFFF] and registered into y_o.
  - Then x_d <= x_i.
- Latency:
  - y_o reflects the x_i sampled at the same edge; it is valid from that edge until the next.
  - The first edge after reset release uses x_d = 0 and y[n-1] = 0.
- Coefficients and offset are not registered. A change affects the computation at the next rising edge; there is no settling handshake.
- No valid/ready handshake: a sample is consumed every cycle.
- Feedback uses the saturated y_o, so an unstable |a| ≥ 1.0 pins the output at a rail and must not wrap.
- Combinational path: inputs → multipliers → adder → saturation → y_o. Single-cycle, no pipelining.

Test Plan:
- Reset: assert reset with nonzero state (y_o = 0x00030000) -> y_o = 0x00000000 immediately, before any clock edge; it stays 0 after release until the first edge.
- Two-tap average: b0 = b1 = 0x00008000, a = 0, offset = 0; x = 0x00010000 step from reset -> y_o = 0x00008000, then 0x00010000 on all later edges.
- Feedback decay: b0 = 0x00010000, b1 = 0, a = 0x00008000; x = 0x00010000 for one cycle then 0 -> y_o = 0x00010000, 0x00008000, 0x00004000, 0x00002000.
- Offset and sign: all coefficients 0, offset = 0x00020000 -> y_o = 0x00020000. Then b0 = 0x00010000, offset = 0, x = 0xFFFF0000 -> y_o = 0xFFFF0000.
- Truncation: b0 = 0x00008000, others 0.
  - x = 0x00000001 -> y_o = 0x00000000.
  - x = 0xFFFFFFFF -> y_o = 0xFFFFFFFF (floor).
- Saturation: b0 = 0x7FFF0000, x = 0x00020000 -> y_o = 0x7FFFFFFF. Then x = 0xFFFE0000 -> y_o = 0x80000000. With a = 0x00010000 and x held, the output stays at the rail with no wrap.
